// File: rtl/zjh_stopwatch_bcd_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM state codes, BCD digit limits
// and the single-digit BCD step used by the cascaded counter.
// Pure declarations; no logic of its own.
package zjh_stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic [3:0] SEC_H_MAX = 4'd5;
  localparam logic [3:0] MIN_H_MAX = 4'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;

  // Advance one BCD digit by carry_in. Returns {carry_out, next_digit}.
  // A digit above its limit (upset) collapses to 0 without producing a carry.
  function automatic logic [4:0] bcd_step(input logic [3:0] dig,
                                          input logic [3:0] lim,
                                          input logic       carry_in);
    logic [4:0] res;
    if (dig > lim)      res = {1'b0, 4'd0};
    else if (!carry_in) res = {1'b0, dig};
    else if (dig == lim) res = {1'b1, 4'd0};
    else                res = {1'b0, dig + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/zjh_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer, rising-edge pulse.
// Pulse appears 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw 0->1 edge.
// Glitches shorter than DEBOUNCE_CYCLES cycles are absorbed; release produces no pulse.
module zjh_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic Clock,
  input  logic Aclr,
  input  logic key_raw,
  output logic key_lvl,
  output logic key_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive samples that disagree with the accepted level,
  // flip the level on the last one, then pulse on the accepted rising edge.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      key_lvl   <= 1'b0;
      lvl_d     <= 1'b0;
      cnt       <= '0;
      key_pulse <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (sync2 != key_lvl) begin
        if (cnt == CNT_LAST) begin
          key_lvl <= sync2;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      lvl_d     <= key_lvl;
      key_pulse <= key_lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/zjh_stopwatch_bcd.sv
// MM:SS stopwatch feeding the scanned 7-segment display: run/pause FSM, prescaler, BCD cascade.
// Digits advance on the prescaler tick edge; keys act one cycle after their debounced pulse.
// No backpressure; all outputs are registered and clear has priority over start/stop.
module zjh_stopwatch_bcd
  import zjh_stopwatch_bcd_pkg::*;
#(
  parameter int TICK_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       Clock,
  input  logic       Aclr,
  input  logic       Key_SS,
  input  logic       Key_Clr,
  output logic [3:0] Sec_L,
  output logic [3:0] Sec_H,
  output logic [3:0] Min_L,
  output logic [3:0] Min_H,
  output logic       Running,
  output logic       Carry
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic          ss_p;
  logic          clr_p;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [4:0]    step_sl;
  logic [4:0]    step_sh;
  logic [4:0]    step_ml;
  logic [4:0]    step_mh;

  zjh_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_ss (
    .Clock     (Clock),
    .Aclr      (Aclr),
    .key_raw   (Key_SS),
    .key_lvl   (),
    .key_pulse (ss_p)
  );

  zjh_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .Clock     (Clock),
    .Aclr      (Aclr),
    .key_raw   (Key_Clr),
    .key_lvl   (),
    .key_pulse (clr_p)
  );

  // Next-state logic: clear dominates, start/stop toggles RUN/PAUSE, code 11 falls back to IDLE.
  always_comb begin
    state_nxt = state;
    if (clr_p) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (ss_p) state_nxt = ST_RUN;
        ST_RUN:   if (ss_p) state_nxt = ST_PAUSE;
        ST_PAUSE: if (ss_p) state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, with Running registered from the next state so it tracks RUN exactly.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      state   <= ST_IDLE;
      Running <= 1'b0;
    end else begin
      state   <= state_nxt;
      Running <= (state_nxt == ST_RUN);
    end
  end

  assign tick = (state == ST_RUN) && (ps_cnt == PS_LAST);

  // Prescaler: counts only in RUN, holds the partial second in PAUSE, sits at 0 otherwise.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      ps_cnt <= '0;
    end else if (clr_p) begin
      ps_cnt <= '0;
    end else begin
      case (state)
        ST_RUN:   ps_cnt <= tick ? '0 : ps_cnt + PW'(1);
        ST_PAUSE: ps_cnt <= ps_cnt;
        default:  ps_cnt <= '0;
      endcase
    end
  end

  // Ripple the tick through the four digits; an upset digit is zeroed by its step.
  always_comb begin
    step_sl = bcd_step(Sec_L, DIG_MAX,   1'b1);
    step_sh = bcd_step(Sec_H, SEC_H_MAX, step_sl[4]);
    step_ml = bcd_step(Min_L, DIG_MAX,   step_sh[4]);
    step_mh = bcd_step(Min_H, MIN_H_MAX, step_ml[4]);
  end

  // Digit registers and the one-cycle wrap pulse out of 59:59.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      Sec_L <= 4'd0;
      Sec_H <= 4'd0;
      Min_L <= 4'd0;
      Min_H <= 4'd0;
      Carry <= 1'b0;
    end else if (clr_p) begin
      Sec_L <= 4'd0;
      Sec_H <= 4'd0;
      Min_L <= 4'd0;
      Min_H <= 4'd0;
      Carry <= 1'b0;
    end else begin
      Carry <= tick & step_mh[4];
      if (tick) begin
        Sec_L <= step_sl[3:0];
        Sec_H <= step_sh[3:0];
        Min_L <= step_ml[3:0];
        Min_H <= step_mh[3:0];
      end
    end
  end

endmodule

// File: tb/tb_zjh_stopwatch_bcd.sv
// Bench for zjh_stopwatch_bcd with TICK_DIV=4, DEBOUNCE_CYCLES=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected digit sequences come from a seconds-based model queued ahead of each run.
module tb_zjh_stopwatch_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ss = 1'b0;
  logic       key_clr = 1'b0;
  logic [3:0] sec_l, sec_h, min_l, min_h;
  logic       running, carry;
  logic [15:0] digits;

  typedef struct packed {
    logic [15:0] t;
    logic        c;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model = 16'h0000;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  zjh_stopwatch_bcd #(.TICK_DIV(4), .DEBOUNCE_CYCLES(2)) dut (
    .Clock   (clk),
    .Aclr    (rst),
    .Key_SS  (key_ss),
    .Key_Clr (key_clr),
    .Sec_L   (sec_l),
    .Sec_H   (sec_h),
    .Min_L   (min_l),
    .Min_H   (min_h),
    .Running (running),
    .Carry   (carry)
  );

  assign digits = {min_h, min_l, sec_h, sec_l};

  function automatic int to_secs(input logic [15:0] t);
    return int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [15:0] from_secs(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] inc_time(input logic [15:0] t);
    return from_secs((to_secs(t) + 1) % 3600);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n, input logic ss, input logic clr);
    key_ss  = ss;
    key_clr = clr;
    repeat (n) next_cyc();
    key_ss  = 1'b0;
    key_clr = 1'b0;
  endtask

  // Queue n model successors, then pop one per observed digit change.
  task automatic expect_ticks(input int n, input string nm);
    exp_t        e;
    logic [15:0] prev;
    bit          got;
    for (int i = 0; i < n; i++) begin
      e.t = inc_time(model);
      e.c = (model == 16'h5959);
      model = e.t;
      sbq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      prev = digits;
      got  = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        next_cyc();
        if (digits !== prev) got = 1'b1;
      end
      e = sbq.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL %s step %0d: no digit change in 12 cycles, digits=%h required %h", nm, i, digits, e.t);
        sbq.delete();
        return;
      end
      if ({digits, carry} !== {e.t, e.c}) begin
        n_err++;
        $display("FAIL %s step %0d: digits=%h carry=%b required digits=%h carry=%b", nm, i, digits, carry, e.t, e.c);
      end
    end
  endtask

  task automatic test_reset();
    bit bad;
    n_cmp++;
    if ({digits, running, carry} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_held_init: got %h/%b/%b required 0000/0/0", digits, running, carry);
    end
    rst = 1'b0;
    next_cyc();
    n_cmp++;
    if ({digits, running, carry} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_release_init: got %h/%b/%b required 0000/0/0", digits, running, carry);
    end
    model = 16'h0000;
    press(3, 1'b1, 1'b0);
    expect_ticks(754, "count_to_1234");
    n_cmp++;
    if (digits !== 16'h1234) begin
      n_err++;
      $display("FAIL reached_1234: digits=%h required 1234", digits);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({digits, running, carry} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_async: got %h/%b/%b required 0000/0/0", digits, running, carry);
    end
    bad = 1'b0;
    repeat (3) begin
      next_cyc();
      if ({digits, running, carry} !== 18'h0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: nonzero output while reset held, last %h/%b/%b required 0000/0/0", digits, running, carry);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      next_cyc();
      if ({digits, running, carry} !== 18'h0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after_release: last %h/%b/%b required 0000/0/0", digits, running, carry);
    end
    model = 16'h0000;
  endtask

  task automatic test_run_start();
    key_ss = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      next_cyc();
      if (k == 10) key_ss = 1'b0;
      if (k == 5) begin
        n_cmp++;
        if (running !== 1'b0) begin n_err++; $display("FAIL start_early: running=%b required 0 at cycle 5", running); end
      end
      if (k == 6) begin
        n_cmp++;
        if (running !== 1'b1) begin n_err++; $display("FAIL start_latency: running=%b required 1 at cycle 6", running); end
      end
      if (k == 9 || k == 13) begin
        n_cmp++;
        if (digits !== ((k == 9) ? 16'h0000 : 16'h0001)) begin
          n_err++;
          $display("FAIL start_hold_c%0d: digits=%h required %h", k, digits, (k == 9) ? 16'h0000 : 16'h0001);
        end
      end
      if (k == 10 || k == 14) begin
        n_cmp++;
        if (digits !== ((k == 10) ? 16'h0001 : 16'h0002)) begin
          n_err++;
          $display("FAIL start_tick_c%0d: digits=%h required %h", k, digits, (k == 10) ? 16'h0001 : 16'h0002);
        end
      end
    end
    model = 16'h0002;
  endtask

  task automatic test_glitch_pause();
    bit bad;
    key_ss = 1'b1;
    next_cyc();
    key_ss = 1'b0;
    expect_ticks(2, "run_after_glitch");
    n_cmp++;
    if (running !== 1'b1) begin n_err++; $display("FAIL glitch_ignored: running=%b required 1", running); end
    // Stable 2-cycle press aligned to a tick edge: one more tick lands before PAUSE.
    key_ss = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_cyc();
      if (k == 2) key_ss = 1'b0;
      if (k == 3) begin
        n_cmp++;
        if (digits !== model) begin n_err++; $display("FAIL pause_pre_tick: digits=%h required %h", digits, model); end
      end
      if (k == 4) begin
        n_cmp++;
        if (digits !== inc_time(model)) begin n_err++; $display("FAIL pause_last_tick: digits=%h required %h", digits, inc_time(model)); end
      end
      if (k == 5 || k == 6) begin
        n_cmp++;
        if (running !== (k == 5)) begin n_err++; $display("FAIL pause_running_c%0d: running=%b required %b", k, running, (k == 5)); end
      end
    end
    model = inc_time(model);
    bad = 1'b0;
    repeat (50) begin
      next_cyc();
      if (digits !== model || running !== 1'b0 || carry !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL pause_freeze: last digits=%h running=%b required %h/0", digits, running, model); end
    // Resume: prescaler held 2 of 3, so the next tick comes two cycles after RUN.
    key_ss = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_cyc();
      if (k == 2) key_ss = 1'b0;
      if (k == 6) begin
        n_cmp++;
        if (running !== 1'b1) begin n_err++; $display("FAIL resume_running: running=%b required 1", running); end
      end
      if (k == 7) begin
        n_cmp++;
        if (digits !== model) begin n_err++; $display("FAIL resume_partial_hold: digits=%h required %h", digits, model); end
      end
      if (k == 8) begin
        n_cmp++;
        if (digits !== inc_time(model)) begin n_err++; $display("FAIL resume_partial_tick: digits=%h required %h", digits, inc_time(model)); end
      end
    end
    model = inc_time(model);
  endtask

  task automatic test_wrap();
    expect_ticks(3598 - to_secs(model), "run_to_5958");
    n_cmp++;
    if (digits !== 16'h5958) begin n_err++; $display("FAIL reach_5958: digits=%h required 5958", digits); end
    expect_ticks(2, "wrap");
    next_cyc();
    n_cmp++;
    if ({carry, running} !== 2'b01) begin
      n_err++;
      $display("FAIL carry_one_cycle: carry=%b running=%b required carry=0 running=1", carry, running);
    end
  endtask

  task automatic test_clear_ss();
    expect_ticks(7, "run_to_0007");
    key_ss  = 1'b1;
    key_clr = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      next_cyc();
      if (k == 3) begin key_ss = 1'b0; key_clr = 1'b0; end
      if (k == 4) begin
        n_cmp++;
        if (digits !== 16'h0008) begin n_err++; $display("FAIL clr_pre_tick: digits=%h required 0008", digits); end
      end
      if (k == 5) begin
        n_cmp++;
        if (running !== 1'b1) begin n_err++; $display("FAIL clr_pre_running: running=%b required 1", running); end
      end
      if (k == 6 || k == 16) begin
        n_cmp++;
        if ({digits, running, carry} !== 18'h0) begin
          n_err++;
          $display("FAIL clr_wins_c%0d: got %h/%b/%b required 0000/0/0", k, digits, running, carry);
        end
      end
    end
    model = 16'h0000;
  endtask

  task automatic test_sweep();
    press(3, 1'b1, 1'b0);
    expect_ticks(600, "sweep");
    n_cmp++;
    if ({min_h, min_l, sec_h, sec_l} !== {4'd1, 4'd0, 4'd0, 4'd0}) begin
      n_err++;
      $display("FAIL sweep_end: digits=%h required 1000", digits);
    end
  endtask

  initial begin
    repeat (3) next_cyc();
    test_reset();
    test_run_start();
    test_glitch_pause();
    test_wrap();
    test_clear_ss();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
